// File: rtl/pd_pkg.sv
// Shared definitions for the decode->execute boundary of the five-stage core.
// Holds datapath widths, the bubble instruction, ALU-B select encodings and
// the packed layout of the execute-stage register bank.
package pd_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned RA_W     = 5;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [RA_W-1:0] X0       = 5'd0;

  // ALU B operand select. Any value with bit 1 set selects the immediate,
  // so SEL_IMM is the canonical encoding of the 2'b1x group.
  localparam logic [1:0] SEL_RS2   = 2'b00;
  localparam logic [1:0] SEL_SHAMT = 2'b01;
  localparam logic [1:0] SEL_IMM   = 2'b10;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic [RA_W-1:0] rd;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] shamt;
    logic            pc_reg1_sel;
    logic [1:0]      imm_rs2_shamt_sel;
    logic            reg_wen;
    logic            mem_read;
    logic            mem_write;
  } ex_regs_t;

  // Bubble: every field zero except the instruction word, which carries a NOP
  // so trace tools and the execute stage see a well-formed instruction.
  function automatic ex_regs_t bubble();
    ex_regs_t b;
    b      = '0;
    b.inst = NOP_INST;
    return b;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector (purely combinational).
// Flags when the instruction in decode reads the register that a load now in
// execute will write; the load data is not available for bypass until after
// the memory stage, so decode must wait one cycle.
// Ports:
//   d_valid_i      decode holds a real instruction
//   d_rs1_i/rs2_i  decode source register addresses
//   e_valid_i      execute holds a real instruction
//   e_mem_read_i   execute instruction is a load
//   e_rd_i         execute destination register
//   hz_o           load-use hazard present
module load_use_detect
  import pd_pkg::*;
(
  input  logic            d_valid_i,
  input  logic [RA_W-1:0] d_rs1_i,
  input  logic [RA_W-1:0] d_rs2_i,
  input  logic            e_valid_i,
  input  logic            e_mem_read_i,
  input  logic [RA_W-1:0] e_rd_i,
  output logic            hz_o
);

  // rs2 is compared even when ALU B takes the immediate or shamt; decode
  // does not tell us whether rs2 is really read (stores need it), so we
  // accept an occasional unnecessary bubble.
  assign hz_o = d_valid_i & e_valid_i & e_mem_read_i & (e_rd_i != X0) &
                ((e_rd_i == d_rs1_i) | (e_rd_i == d_rs2_i));

endmodule

// File: rtl/decode_execute_reg.sv
// Decode->execute pipeline register with load-use hazard control.
// Latches decoded operands/controls every cycle; on a load-use hazard a single
// bubble is inserted while stall_fd holds fetch/decode, and on a taken branch
// resolved in execute (flush) the decode instruction is squashed to a bubble.
// Ports:
//   clock, reset           rising-edge clock, synchronous active-high reset
//   d_*                    decoded instruction fields from the decode stage
//   flush                  taken branch/jump in execute, squash decode
//   e_*                    registered copies of d_*, plus e_valid
//   stall_fd               hold PC and fetch/decode registers this cycle
//   stall_cnt, flush_cnt   bubble counters (load-use / flush), wrap mod 2^32
// Stall protocol: when stall_fd is high this cycle, upstream must present the
// same decode instruction again next cycle; this block consumes the decode
// instruction only on a cycle where stall_fd is low.
module decode_execute_reg
  import pd_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            d_valid,
  input  logic [XLEN-1:0] d_pc,
  input  logic [XLEN-1:0] d_inst,
  input  logic [RA_W-1:0] d_rs1,
  input  logic [RA_W-1:0] d_rs2,
  input  logic [RA_W-1:0] d_rd,
  input  logic [XLEN-1:0] d_rs1_data,
  input  logic [XLEN-1:0] d_rs2_data,
  input  logic [XLEN-1:0] d_imm,
  input  logic [XLEN-1:0] d_shamt,
  input  logic            d_pc_reg1_sel,
  input  logic [1:0]      d_imm_rs2_shamt_sel,
  input  logic            d_reg_wen,
  input  logic            d_mem_read,
  input  logic            d_mem_write,
  input  logic            flush,
  output logic            e_valid,
  output logic [XLEN-1:0] e_pc,
  output logic [XLEN-1:0] e_inst,
  output logic [RA_W-1:0] e_rs1,
  output logic [RA_W-1:0] e_rs2,
  output logic [RA_W-1:0] e_rd,
  output logic [XLEN-1:0] e_rs1_data,
  output logic [XLEN-1:0] e_rs2_data,
  output logic [XLEN-1:0] e_imm,
  output logic [XLEN-1:0] e_shamt,
  output logic            e_pc_reg1_sel,
  output logic [1:0]      e_imm_rs2_shamt_sel,
  output logic            e_reg_wen,
  output logic            e_mem_read,
  output logic            e_mem_write,
  output logic            stall_fd,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     flush_cnt
);

  ex_regs_t    e_q, e_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic        hz;

  load_use_detect u_load_use_detect (
    .d_valid_i    (d_valid),
    .d_rs1_i      (d_rs1),
    .d_rs2_i      (d_rs2),
    .e_valid_i    (e_q.valid),
    .e_mem_read_i (e_q.mem_read),
    .e_rd_i       (e_q.rd),
    .hz_o         (hz)
  );

  // A flush squashes decode anyway, so holding fetch/decode would be wrong.
  assign stall_fd = hz & ~flush;

  always_comb begin
    e_d         = bubble();
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (flush) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end else if (hz) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else if (d_valid) begin
      e_d.valid             = 1'b1;
      e_d.pc                = d_pc;
      e_d.inst              = d_inst;
      e_d.rs1               = d_rs1;
      e_d.rs2               = d_rs2;
      e_d.rd                = d_rd;
      e_d.rs1_data          = d_rs1_data;
      e_d.rs2_data          = d_rs2_data;
      e_d.imm               = d_imm;
      e_d.shamt             = d_shamt;
      e_d.pc_reg1_sel       = d_pc_reg1_sel;
      e_d.imm_rs2_shamt_sel = d_imm_rs2_shamt_sel;
      e_d.reg_wen           = d_reg_wen;
      e_d.mem_read          = d_mem_read;
      e_d.mem_write         = d_mem_write;
    end
    // The downstream bypass compares rd without an x0 guard, so a
    // non-writing instruction must never advertise a destination.
    if (!e_d.reg_wen) e_d.rd = X0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      e_q         <= bubble();
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      e_q         <= e_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign e_valid             = e_q.valid;
  assign e_pc                = e_q.pc;
  assign e_inst              = e_q.inst;
  assign e_rs1               = e_q.rs1;
  assign e_rs2               = e_q.rs2;
  assign e_rd                = e_q.rd;
  assign e_rs1_data          = e_q.rs1_data;
  assign e_rs2_data          = e_q.rs2_data;
  assign e_imm               = e_q.imm;
  assign e_shamt             = e_q.shamt;
  assign e_pc_reg1_sel       = e_q.pc_reg1_sel;
  assign e_imm_rs2_shamt_sel = e_q.imm_rs2_shamt_sel;
  assign e_reg_wen           = e_q.reg_wen;
  assign e_mem_read          = e_q.mem_read;
  assign e_mem_write         = e_q.mem_write;
  assign stall_cnt           = stall_cnt_q;
  assign flush_cnt           = flush_cnt_q;

endmodule

// File: tb/tb_decode_execute_reg.sv
module tb_decode_execute_reg;

  logic        clock;
  logic        reset;
  logic        d_valid;
  logic [31:0] d_pc, d_inst;
  logic [4:0]  d_rs1, d_rs2, d_rd;
  logic [31:0] d_rs1_data, d_rs2_data, d_imm, d_shamt;
  logic        d_pc_reg1_sel;
  logic [1:0]  d_imm_rs2_shamt_sel;
  logic        d_reg_wen, d_mem_read, d_mem_write;
  logic        flush;
  logic        e_valid;
  logic [31:0] e_pc, e_inst;
  logic [4:0]  e_rs1, e_rs2, e_rd;
  logic [31:0] e_rs1_data, e_rs2_data, e_imm, e_shamt;
  logic        e_pc_reg1_sel;
  logic [1:0]  e_imm_rs2_shamt_sel;
  logic        e_reg_wen, e_mem_read, e_mem_write;
  logic        stall_fd;
  logic [31:0] stall_cnt, flush_cnt;

  int checks   = 0;
  int failures = 0;

  decode_execute_reg dut (
    .clock               (clock),
    .reset               (reset),
    .d_valid             (d_valid),
    .d_pc                (d_pc),
    .d_inst              (d_inst),
    .d_rs1               (d_rs1),
    .d_rs2               (d_rs2),
    .d_rd                (d_rd),
    .d_rs1_data          (d_rs1_data),
    .d_rs2_data          (d_rs2_data),
    .d_imm               (d_imm),
    .d_shamt             (d_shamt),
    .d_pc_reg1_sel       (d_pc_reg1_sel),
    .d_imm_rs2_shamt_sel (d_imm_rs2_shamt_sel),
    .d_reg_wen           (d_reg_wen),
    .d_mem_read          (d_mem_read),
    .d_mem_write         (d_mem_write),
    .flush               (flush),
    .e_valid             (e_valid),
    .e_pc                (e_pc),
    .e_inst              (e_inst),
    .e_rs1               (e_rs1),
    .e_rs2               (e_rs2),
    .e_rd                (e_rd),
    .e_rs1_data          (e_rs1_data),
    .e_rs2_data          (e_rs2_data),
    .e_imm               (e_imm),
    .e_shamt             (e_shamt),
    .e_pc_reg1_sel       (e_pc_reg1_sel),
    .e_imm_rs2_shamt_sel (e_imm_rs2_shamt_sel),
    .e_reg_wen           (e_reg_wen),
    .e_mem_read          (e_mem_read),
    .e_mem_write         (e_mem_write),
    .stall_fd            (stall_fd),
    .stall_cnt           (stall_cnt),
    .flush_cnt           (flush_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge; inputs are driven and outputs sampled 1 time
  // unit after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_inst(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                            input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                            input logic wen, input logic mrd, input logic mwr);
    d_valid             = v;
    d_pc                = pc;
    d_inst              = inst;
    d_rs1               = rs1;
    d_rs2               = rs2;
    d_rd                = rd;
    d_reg_wen           = wen;
    d_mem_read          = mrd;
    d_mem_write         = mwr;
    d_rs1_data          = 32'hA000_0000 | pc;
    d_rs2_data          = 32'hB000_0000 | pc;
    d_imm               = 32'h0000_0010;
    d_shamt             = 32'h0000_0003;
    d_pc_reg1_sel       = 1'b0;
    d_imm_rs2_shamt_sel = 2'b00;
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive_inst(1'b1, 32'h0000_0200, 32'h0050_0293, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);
    flush = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    checks++; if (e_valid !== 1'b0) begin failures++; $display("FAIL reset_e_valid got=%0h exp=0", e_valid); end
    checks++; if (e_inst !== 32'h13) begin failures++; $display("FAIL reset_e_inst got=%h exp=00000013", e_inst); end
    checks++; if (e_pc !== 32'h0 || e_rd !== 5'd0 || e_reg_wen !== 1'b0) begin
      failures++; $display("FAIL reset_fields got pc=%h rd=%0d wen=%0b exp 0", e_pc, e_rd, e_reg_wen); end
    checks++; if (stall_cnt !== 32'h0 || flush_cnt !== 32'h0) begin
      failures++; $display("FAIL reset_counters got stall=%0d flush=%0d exp 0", stall_cnt, flush_cnt); end
    checks++; if (stall_fd !== 1'b0) begin failures++; $display("FAIL reset_stall_fd got=%0b exp=0", stall_fd); end
    reset = 1'b0;
  endtask

  task automatic test_pass_through();
    do_reset();
    drive_inst(1'b1, 32'h0000_0100, 32'h0010_8293, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);
    d_pc_reg1_sel       = 1'b1;
    d_imm_rs2_shamt_sel = 2'b10;
    tick();
    checks++; if (e_pc !== 32'h100 || e_rd !== 5'd5 || e_valid !== 1'b1) begin
      failures++; $display("FAIL pass_basic got pc=%h rd=%0d v=%0b exp pc=100 rd=5 v=1", e_pc, e_rd, e_valid); end
    checks++; if (e_inst !== 32'h0010_8293 || e_rs1 !== 5'd1 || e_rs2 !== 5'd2) begin
      failures++; $display("FAIL pass_inst got inst=%h rs1=%0d rs2=%0d", e_inst, e_rs1, e_rs2); end
    checks++; if (e_rs1_data !== 32'hA000_0100 || e_rs2_data !== 32'hB000_0100 || e_imm !== 32'h10 || e_shamt !== 32'h3) begin
      failures++; $display("FAIL pass_data got r1=%h r2=%h imm=%h sh=%h", e_rs1_data, e_rs2_data, e_imm, e_shamt); end
    checks++; if (e_pc_reg1_sel !== 1'b1 || e_imm_rs2_shamt_sel !== 2'b10 || e_reg_wen !== 1'b1 || e_mem_read !== 1'b0) begin
      failures++; $display("FAIL pass_ctrl got a=%0b b=%0b wen=%0b mrd=%0b", e_pc_reg1_sel, e_imm_rs2_shamt_sel, e_reg_wen, e_mem_read); end
    checks++; if (stall_fd !== 1'b0) begin failures++; $display("FAIL pass_stall_fd got=%0b exp=0", stall_fd); end
    // store: mem_write passes, reg_wen=0 forces rd to 0
    drive_inst(1'b1, 32'h0000_0104, 32'h0053_2023, 5'd6, 5'd5, 5'd7, 1'b0, 1'b0, 1'b1);
    tick();
    checks++; if (e_mem_write !== 1'b1 || e_rd !== 5'd0 || e_pc !== 32'h104) begin
      failures++; $display("FAIL rd_invariant got mwr=%0b rd=%0d pc=%h exp mwr=1 rd=0 pc=104", e_mem_write, e_rd, e_pc); end
  endtask

  task automatic test_load_use();
    do_reset();
    drive_inst(1'b1, 32'h0000_0104, 32'h0001_2283, 5'd2, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0);  // lw x5
    tick();
    drive_inst(1'b1, 32'h0000_0108, 32'h0012_8333, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0, 1'b0);  // add x6,x5,x1
    checks++; if (stall_fd !== 1'b1) begin failures++; $display("FAIL lu_stall_fd got=%0b exp=1", stall_fd); end
    tick();
    checks++; if (e_valid !== 1'b0 || e_inst !== 32'h13 || e_rd !== 5'd0 || e_mem_read !== 1'b0) begin
      failures++; $display("FAIL lu_bubble got v=%0b inst=%h rd=%0d mrd=%0b", e_valid, e_inst, e_rd, e_mem_read); end
    checks++; if (stall_cnt !== 32'd1 || flush_cnt !== 32'd0) begin
      failures++; $display("FAIL lu_stall_cnt got stall=%0d flush=%0d exp 1/0", stall_cnt, flush_cnt); end
    checks++; if (stall_fd !== 1'b0) begin failures++; $display("FAIL lu_stall_release got=%0b exp=0", stall_fd); end
    tick();  // decode held the add; it now issues
    checks++; if (e_valid !== 1'b1 || e_pc !== 32'h108 || e_rd !== 5'd6 || stall_cnt !== 32'd1) begin
      failures++; $display("FAIL lu_reissue got v=%0b pc=%h rd=%0d cnt=%0d", e_valid, e_pc, e_rd, stall_cnt); end
    // rs2 dependence counts even with the immediate selected
    drive_inst(1'b1, 32'h0000_010C, 32'h0001_2283, 5'd2, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0);
    tick();
    drive_inst(1'b1, 32'h0000_0110, 32'h0051_2223, 5'd3, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1);
    d_imm_rs2_shamt_sel = 2'b10;
    #1;
    checks++; if (stall_fd !== 1'b1) begin failures++; $display("FAIL lu_rs2_stall got=%0b exp=1", stall_fd); end
    tick();
    checks++; if (stall_cnt !== 32'd2) begin failures++; $display("FAIL lu_rs2_cnt got=%0d exp=2", stall_cnt); end
  endtask

  task automatic test_no_false_hazard();
    do_reset();
    drive_inst(1'b1, 32'h0000_0200, 32'h0001_2003, 5'd2, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);  // lw x0
    tick();
    drive_inst(1'b1, 32'h0000_0204, 32'h0000_0393, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0);
    checks++; if (stall_fd !== 1'b0) begin failures++; $display("FAIL nf_x0_stall got=%0b exp=0", stall_fd); end
    tick();
    checks++; if (e_valid !== 1'b1 || e_pc !== 32'h204) begin
      failures++; $display("FAIL nf_x0_issue got v=%0b pc=%h exp v=1 pc=204", e_valid, e_pc); end
    drive_inst(1'b1, 32'h0000_0208, 32'h0020_82B3, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);  // add x5
    tick();
    drive_inst(1'b1, 32'h0000_020C, 32'h0012_8333, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0, 1'b0);
    checks++; if (stall_fd !== 1'b0) begin failures++; $display("FAIL nf_alu_stall got=%0b exp=0", stall_fd); end
    tick();
    checks++; if (e_pc !== 32'h20C || e_valid !== 1'b1 || stall_cnt !== 32'd0) begin
      failures++; $display("FAIL nf_alu_issue got pc=%h v=%0b cnt=%0d", e_pc, e_valid, stall_cnt); end
    // lw x5 followed by an invalid decode slot: no hazard, bubble-like load
    drive_inst(1'b1, 32'h0000_0210, 32'h0001_2283, 5'd2, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0);
    tick();
    drive_inst(1'b0, 32'h0000_0214, 32'h0012_8333, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0, 1'b0);
    checks++; if (stall_fd !== 1'b0) begin failures++; $display("FAIL nf_invalid_stall got=%0b exp=0", stall_fd); end
    tick();
    checks++; if (e_valid !== 1'b0 || e_inst !== 32'h13 || e_rd !== 5'd0 || e_pc !== 32'h0 || e_reg_wen !== 1'b0 || stall_cnt !== 32'd0) begin
      failures++; $display("FAIL nf_invalid_bubble got v=%0b inst=%h rd=%0d pc=%h wen=%0b cnt=%0d",
                           e_valid, e_inst, e_rd, e_pc, e_reg_wen, stall_cnt); end
  endtask

  task automatic test_flush_hazard();
    do_reset();
    drive_inst(1'b1, 32'h0000_0300, 32'h0001_2283, 5'd2, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0);
    tick();
    drive_inst(1'b1, 32'h0000_0304, 32'h0012_8333, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0, 1'b0);
    flush = 1'b1;
    #1;
    checks++; if (stall_fd !== 1'b0) begin failures++; $display("FAIL fh_stall_fd got=%0b exp=0", stall_fd); end
    tick();
    flush = 1'b0;
    checks++; if (e_valid !== 1'b0 || e_inst !== 32'h13 || e_rd !== 5'd0) begin
      failures++; $display("FAIL fh_bubble got v=%0b inst=%h rd=%0d", e_valid, e_inst, e_rd); end
    checks++; if (flush_cnt !== 32'd1 || stall_cnt !== 32'd0) begin
      failures++; $display("FAIL fh_counters got flush=%0d stall=%0d exp 1/0", flush_cnt, stall_cnt); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    drive_inst(1'b1, 32'h0000_0400, 32'h0001_2283, 5'd2, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0);
    tick();
    drive_inst(1'b1, 32'h0000_0404, 32'h0012_8333, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++; if (e_valid !== 1'b0 || stall_fd !== 1'b0 || stall_cnt !== 32'd0) begin
      failures++; $display("FAIL rst_mid_stall got v=%0b stall_fd=%0b cnt=%0d exp 0/0/0", e_valid, stall_fd, stall_cnt); end
  endtask

  task automatic test_wrap();
    do_reset();
    drive_inst(1'b0, 32'h0, 32'h13, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    force dut.flush_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.flush_cnt_q;
    flush = 1'b1;
    #1;
    checks++; if (flush_cnt !== 32'hFFFF_FFFF) begin failures++; $display("FAIL wrap_preload got=%h exp=ffffffff", flush_cnt); end
    tick();
    flush = 1'b0;
    checks++; if (flush_cnt !== 32'h0) begin failures++; $display("FAIL wrap_flush_cnt got=%h exp=00000000", flush_cnt); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    reset = 1'b1;
    flush = 1'b0;
    drive_inst(1'b0, 32'h0, 32'h13, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_pass_through();
    test_load_use();
    test_no_false_hazard();
    test_flush_hazard();
    test_reset_mid_stall();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
